// File: rtl/ps2_rx_fifo_if.sv
// Receive-side handshake bundle for ps2_rx_fifo: show-ahead head entry plus valid/ready.
// Handshake: an entry transfers on any clk edge where rx_valid & rx_ready are both 1; rx_valid never depends on rx_ready.
interface ps2_rx_fifo_if;
  logic [7:0] rx_data;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data, rx_parity_err, rx_frame_err, rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_parity_err, rx_frame_err, rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: sync + deglitch, 11-bit deframer with parity/stop/timeout checks, show-ahead FIFO.
// Optional error counters (cnt_parity, cnt_frame, cnt_timeout) exist only when PS2_ERR_CNT_EN is defined.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  ps2_rx_fifo_if.master                   rx,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            busy,
  output logic                            err_timeout,
  output logic                            err_overflow,
  input  logic                            err_clr
`ifdef PS2_ERR_CNT_EN
  ,
  output logic [7:0]                      cnt_parity,
  output logic [7:0]                      cnt_frame,
  output logic [7:0]                      cnt_timeout
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          sample_w;

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_timeout_q;
  logic          timeout_w, push_w;
  logic [9:0]    push_entry;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_ovf_q, err_ovf_d;
  logic          full_w, pop_w, wr_en_w, ovf_set_w;

  // Filtered clock only follows the synced clock once it has disagreed for FILTER_LEN cycles in a row.
  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = ~filt_q;
      else                                  flt_cnt_d = flt_cnt_q + 1'b1;
    end
  end

  assign sample_w = filt_q & ~filt_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    timer_d   = timer_q;
    timeout_w = 1'b0;
    push_w    = 1'b0;
    if (state_q == IDLE) begin
      if (sample_w && !dat_s2_q) begin
        state_d   = DATA;
        bit_cnt_d = '0;
        timer_d   = '0;
      end
    end else if (sample_w) begin
      timer_d = '0;
      case (state_q)
        DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
        STOP: begin
          push_w  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
      timeout_w = 1'b1;
      state_d   = IDLE;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Entry layout: {frame_err, parity_err, data}
  assign push_entry = {~dat_s2_q, ~^{shift_q, par_q}, shift_q};

  assign full_w    = (count_q == CW'(FIFO_DEPTH));
  assign pop_w     = rx.rx_valid & rx.rx_ready;
  assign wr_en_w   = push_w & (~full_w | pop_w);
  assign ovf_set_w = push_w & full_w & ~pop_w;

  always_comb begin
    wr_ptr_d  = wr_en_w ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop_w   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    case ({wr_en_w, pop_w})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    err_ovf_d = ovf_set_w ? 1'b1 : (err_clr ? 1'b0 : err_ovf_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q      <= 1'b1;
      clk_s2_q      <= 1'b1;
      dat_s1_q      <= 1'b1;
      dat_s2_q      <= 1'b1;
      filt_q        <= 1'b1;
      flt_cnt_q     <= '0;
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      timer_q       <= '0;
      err_timeout_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      err_ovf_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      clk_s1_q      <= ps2_clk;
      clk_s2_q      <= clk_s1_q;
      dat_s1_q      <= ps2_data;
      dat_s2_q      <= dat_s1_q;
      filt_q        <= filt_d;
      flt_cnt_q     <= flt_cnt_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      timer_q       <= timer_d;
      err_timeout_q <= timeout_w;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      err_ovf_q     <= err_ovf_d;
      if (wr_en_w) mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign rx.rx_data       = mem_q[rd_ptr_q][7:0];
  assign rx.rx_parity_err = mem_q[rd_ptr_q][8];
  assign rx.rx_frame_err  = mem_q[rd_ptr_q][9];
  assign rx.rx_valid      = (count_q != '0);
  assign fifo_count       = count_q;
  assign busy             = (state_q != IDLE);
  assign err_timeout      = err_timeout_q;
  assign err_overflow     = err_ovf_q;

`ifdef PS2_ERR_CNT_EN
  logic [7:0] cnt_par_q, cnt_par_d, cnt_frm_q, cnt_frm_d, cnt_tmo_q, cnt_tmo_d;

  // Counted at the STOP sample, so frames later dropped for overflow still register their errors.
  always_comb begin
    cnt_par_d = cnt_par_q;
    cnt_frm_d = cnt_frm_q;
    cnt_tmo_d = cnt_tmo_q;
    if (err_clr) begin
      cnt_par_d = '0;
      cnt_frm_d = '0;
      cnt_tmo_d = '0;
    end else begin
      if (push_w && push_entry[8] && cnt_par_q != 8'hFF) cnt_par_d = cnt_par_q + 1'b1;
      if (push_w && push_entry[9] && cnt_frm_q != 8'hFF) cnt_frm_d = cnt_frm_q + 1'b1;
      if (timeout_w && cnt_tmo_q != 8'hFF)               cnt_tmo_d = cnt_tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_par_q <= '0;
      cnt_frm_q <= '0;
      cnt_tmo_q <= '0;
    end else begin
      cnt_par_q <= cnt_par_d;
      cnt_frm_q <= cnt_frm_d;
      cnt_tmo_q <= cnt_tmo_d;
    end
  end

  assign cnt_parity  = cnt_par_q;
  assign cnt_frame   = cnt_frm_q;
  assign cnt_timeout = cnt_tmo_q;
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: bit-level PS/2 frame driver, queue-based FIFO model, randomized frames.
module tb_ps2_rx_fifo;
  localparam int DEPTH = 8;
  localparam int FLT   = 4;
  localparam int TMO   = 1000;
  localparam int HALF  = 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       err_clr = 1'b0;
  logic [3:0] fifo_count;
  logic       busy, err_timeout, err_overflow;
`ifdef PS2_ERR_CNT_EN
  logic [7:0] cnt_parity, cnt_frame, cnt_timeout;
`endif

  ps2_rx_fifo_if rx_if ();

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .rx           (rx_if.master),
    .fifo_count   (fifo_count),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .err_overflow (err_overflow),
    .err_clr      (err_clr)
`ifdef PS2_ERR_CNT_EN
    ,
    .cnt_parity   (cnt_parity),
    .cnt_frame    (cnt_frame),
    .cnt_timeout  (cnt_timeout)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // scoreboard
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [9:0] exp_q[$];
  logic       exp_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  // Reference entry: {frame_err, parity_err, data}; odd parity means data+parity has an odd count of ones.
  function automatic logic [9:0] ref_entry(input logic [7:0] d, input logic p, input logic s);
    int ones;
    ones = $countones(d) + int'(p);
    return {~s, (ones % 2 == 0), d};
  endfunction

  task automatic model_push(input logic [7:0] d, input logic p, input logic s);
    if (exp_q.size() < DEPTH) exp_q.push_back(ref_entry(d, p, s));
    else                      exp_ovf = 1'b1;
  endtask

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cyc(HALF / 2);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
    cyc(HALF / 2);
  endtask

  task automatic glitch();
    ps2_clk = 1'b0;
    cyc(2);
    ps2_clk = 1'b1;
    cyc(20);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    exp_ovf = 1'b0;
  endtask

  // Drives a full frame; the stop bit is watched cycle by cycle so push latency and
  // a pop coinciding with the STOP sample can be exercised.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int glitch_at, input bit chk_lat, input bit pop_at_stop);
    logic [10:0] f;
    logic        prev_v, done;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      send_bit(f[i]);
      if (i == glitch_at) glitch();
    end
    ps2_data = s;
    cyc(HALF / 2);
    ps2_clk = 1'b0;
    prev_v = 1'b0;
    done   = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (pop_at_stop) rx_if.rx_ready = 1'b0;
      if (!busy) done = 1'b1;
      else begin
        prev_v = rx_if.rx_valid;
        if (pop_at_stop && dut.sample_w) rx_if.rx_ready = 1'b1;
      end
    end
    chk("stop_sample_seen", done, 1);
    if (pop_at_stop) begin
      void'(exp_q.pop_front());
      exp_q.push_back(ref_entry(d, p, s));
    end else begin
      model_push(d, p, s);
    end
    if (chk_lat) begin
      chk("valid_before_push", prev_v, 0);
      chk("valid_after_push", rx_if.rx_valid, 1);
    end
    cyc(HALF - 10);
    ps2_clk = 1'b1;
    cyc(HALF / 2);
  endtask

  task automatic drain();
    int         g;
    logic [9:0] e;
    g = 0;
    while (exp_q.size() > 0 && g < DEPTH + 4) begin
      g++;
      @(negedge clk);
      chk("head_valid", rx_if.rx_valid, 1);
      e = exp_q.pop_front();
      chk("head_data", rx_if.rx_data, e[7:0]);
      chk("head_parity_err", rx_if.rx_parity_err, e[8]);
      chk("head_frame_err", rx_if.rx_frame_err, e[9]);
      rx_if.rx_ready = 1'b1;
      @(posedge clk);
      #1;
      rx_if.rx_ready = 1'b0;
    end
    @(negedge clk);
    chk("drained_valid", rx_if.rx_valid, 0);
    chk("drained_count", fifo_count, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, rx_if.rx_valid, 0);
    chk({tag, "_count"}, fifo_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout"}, err_timeout, 0);
    chk({tag, "_overflow"}, err_overflow, 0);
    chk({tag, "_data"}, rx_if.rx_data, 0);
    chk({tag, "_perr"}, rx_if.rx_parity_err, 0);
    chk({tag, "_ferr"}, rx_if.rx_frame_err, 0);
  endtask

  initial begin
    int         pulses;
    logic [7:0] d;
    logic       p, s;
    rx_if.rx_ready = 1'b0;

    cyc(3);
    @(negedge clk);
    chk_reset_vals("reset");
    #1 reset_n = 1'b1;
    cyc(5);

    // Single good frame with push-latency check
    send_frame(8'h1C, 1'b0, 1'b1, -1, 1, 0);
    @(negedge clk);
    chk("t1_count", fifo_count, 1);
    drain();

    // Parity error, then framing error
    send_frame(8'h1C, 1'b1, 1'b1, -1, 0, 0);
    send_frame(8'hF0, odd_par(8'hF0), 1'b0, -1, 0, 0);
    drain();

    // Overflow: DEPTH+1 frames with no consumer
    for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), odd_par(8'(i)), 1'b1, -1, 0, 0);
    @(negedge clk);
    chk("ovf_count", fifo_count, DEPTH);
    chk("ovf_flag", err_overflow, exp_ovf);
    pulse_clr();
    @(negedge clk);
    chk("ovf_cleared", err_overflow, 0);

    // Full FIFO, pop in the exact STOP-sample cycle
    send_frame(8'h0A, odd_par(8'h0A), 1'b1, -1, 0, 1);
    @(negedge clk);
    chk("simul_count", fifo_count, DEPTH);
    chk("simul_no_ovf", err_overflow, 0);
    drain();

    // Timeout after start + 4 data bits
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
    pulses = 0;
    for (int k = 0; k < TMO + 200; k++) begin
      @(negedge clk);
      if (err_timeout) pulses++;
    end
    chk("tmo_pulses", pulses, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_no_push", fifo_count, 0);
    send_frame(8'h5A, odd_par(8'h5A), 1'b1, -1, 0, 0);
    drain();

    // Glitches: idle line (data low so a false sample would start a frame), then mid-frame
    ps2_data = 1'b0;
    glitch();
    @(negedge clk);
    chk("glitch_idle_busy", busy, 0);
    ps2_data = 1'b1;
    cyc(20);
    send_frame(8'h29, odd_par(8'h29), 1'b1, 3, 0, 0);
    drain();

    // Randomized frames with random draining
    for (int r = 0; r < 7; r++) begin
      d = 8'($urandom_range(0, 255));
      p = ($urandom_range(0, 3) == 0) ? ~odd_par(d) : odd_par(d);
      s = ($urandom_range(0, 3) != 0);
      send_frame(d, p, s, -1, 0, 0);
      if ($urandom_range(0, 2) == 0) drain();
    end
    @(negedge clk);
    chk("rand_ovf", err_overflow, exp_ovf);
    drain();
    pulse_clr();

    // Asynchronous reset with data queued and a frame in flight
    send_frame(8'h33, odd_par(8'h33), 1'b1, -1, 0, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2_data = 1'b0;
    cyc(HALF / 2);
    ps2_clk = 1'b0;
    cyc(20);
    @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_count", fifo_count, 1);
    #2 reset_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    exp_q.delete();
    exp_ovf  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    cyc(5);
    reset_n = 1'b1;
    cyc(20);
    @(negedge clk);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_count", fifo_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
